// File: rtl/pc_gen_pkg.sv
// Shared definitions for the IF-stage fetch-address generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Build option PC_MISALIGN_CHK_EN is consumed by pc_next_sel and pc_gen.
package pc_gen_pkg;

  // Stall bus width from ctrl, and its "nothing stalled" value.
  localparam int StallBus = 6;
  localparam logic [StallBus-1:0] NoStop = '0;

  // Instruction-memory enable levels.
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  // Default fetch granule in bytes.
  localparam int INST_BYTES_DEF = 4;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    PC_S_OFF  = 2'd0,
    PC_S_RUN  = 2'd1,
    PC_S_PEND = 2'd2
  } pc_state_e;

  // Which next-PC source won the priority mux this cycle.
  typedef enum logic [2:0] {
    SEL_HOLD  = 3'd0,  // nothing changes
    SEL_FLUSH = 3'd1,  // exception redirect
    SEL_PEND  = 3'd2,  // release of a captured branch
    SEL_BR    = 3'd3,  // live branch taken immediately
    SEL_CAP   = 3'd4,  // branch captured while fetch cannot advance
    SEL_INC   = 3'd5   // sequential fetch
  } pc_sel_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux: flush > pending branch > live branch/capture > increment.
// Latency: 0 cycles (pure combinational; the caller registers the result).
// Backpressure: honours advance_i only; flush is applied regardless. Uses PC_MISALIGN_CHK_EN.
import pc_gen_pkg::*;

module pc_next_sel #(
  parameter int ADDR_W     = 32,
  parameter int INST_BYTES = INST_BYTES_DEF
) (
  input  pc_state_e          state_i,
  input  logic               advance_i,
  input  logic               flush_i,
  input  logic [ADDR_W-1:0]  new_pc_i,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [ADDR_W-1:0]  pend_pc_i,
  output pc_sel_e            sel_o,
  output logic [ADDR_W-1:0]  pc_nxt_o,
  output logic [ADDR_W-1:0]  pend_nxt_o,
  output logic               misalign_nxt_o
);

  // Low address bits that must be zero for an aligned fetch (all-zero when INST_BYTES = 1).
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] INC      = ADDR_W'(INST_BYTES);

  logic [ADDR_W-1:0] new_pc_fix;
  logic [ADDR_W-1:0] br_tgt_fix;
  logic [ADDR_W-1:0] pend_fix;

`ifdef PC_MISALIGN_CHK_EN
  // Redirect addresses are passed through untouched; misalign_o flags them instead.
  assign new_pc_fix = new_pc_i;
  assign br_tgt_fix = branch_target_i;
  assign pend_fix   = pend_pc_i;
`else
  // Redirect addresses are forced onto an instruction boundary.
  assign new_pc_fix = new_pc_i & ~LOW_MASK;
  assign br_tgt_fix = branch_target_i & ~LOW_MASK;
  assign pend_fix   = pend_pc_i & ~LOW_MASK;
`endif

  // Priority selection of the next PC, pending target and misalign flag.
  always_comb begin
    sel_o          = SEL_HOLD;
    pc_nxt_o       = pc_i;
    pend_nxt_o     = pend_pc_i;
    misalign_nxt_o = 1'b0;
    if (state_i != PC_S_OFF) begin
      if (flush_i) begin
        sel_o          = SEL_FLUSH;
        pc_nxt_o       = new_pc_fix;
        pend_nxt_o     = '0;
        misalign_nxt_o = |(new_pc_i & LOW_MASK);
      end else if (state_i == PC_S_PEND && advance_i) begin
        sel_o          = SEL_PEND;
        pc_nxt_o       = pend_fix;
        misalign_nxt_o = |(pend_pc_i & LOW_MASK);
      end else if (state_i == PC_S_RUN && branch_flag_i && advance_i) begin
        sel_o          = SEL_BR;
        pc_nxt_o       = br_tgt_fix;
        misalign_nxt_o = |(branch_target_i & LOW_MASK);
      end else if (state_i == PC_S_RUN && branch_flag_i) begin
        // First capture wins; in PEND a re-presented branch never reaches here.
        sel_o      = SEL_CAP;
        pend_nxt_o = br_tgt_fix;
      end else if (state_i == PC_S_RUN && advance_i) begin
        sel_o    = SEL_INC;
        pc_nxt_o = pc_i + INC;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// IF-stage fetch-address generator: PC register, imem chip enable, branch capture under stall.
// Latency: redirects and increments appear on pc_o one cycle after the deciding edge.
// Backpressure: stall_i[0]=1 or inst_ready_i=0 holds pc_o; branches seen then are captured.
// Build option: PC_MISALIGN_CHK_EN keeps misaligned redirects and reports them on misalign_o.
import pc_gen_pkg::*;

module pc_gen #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter int                INST_BYTES = INST_BYTES_DEF,
  parameter int                STALL_W    = StallBus
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic [ADDR_W-1:0]  new_pc_i,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_address_i,
  input  logic               inst_ready_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               ce_o,
  output logic               misalign_o
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              ce_q, ce_d;
  logic              advance;

  pc_sel_e           sel;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pend_nxt;
  logic              misalign_nxt;

  // Only bit 0 of the ctrl stall vector concerns fetch.
  logic unused_stall;
  assign unused_stall = ^stall_i;

  assign advance = ce_q & ~stall_i[0] & inst_ready_i;

  pc_next_sel #(
    .ADDR_W     (ADDR_W),
    .INST_BYTES (INST_BYTES)
  ) u_next_sel (
    .state_i         (state_q),
    .advance_i       (advance),
    .flush_i         (flush_i),
    .new_pc_i        (new_pc_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_address_i),
    .pc_i            (pc_q),
    .pend_pc_i       (pend_pc_q),
    .sel_o           (sel),
    .pc_nxt_o        (pc_nxt),
    .pend_nxt_o      (pend_nxt),
    .misalign_nxt_o  (misalign_nxt)
  );

  // Fetch FSM next state: OFF turns the memory on, RUN/PEND follow the mux decision.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    ce_d      = ce_q;
    case (state_q)
      PC_S_OFF: begin
        state_d = PC_S_RUN;
        ce_d    = ChipEnable;
      end
      default: begin
        pc_d      = pc_nxt;
        pend_pc_d = pend_nxt;
        case (sel)
          SEL_FLUSH, SEL_PEND: state_d = PC_S_RUN;
          SEL_CAP:             state_d = PC_S_PEND;
          default:             state_d = state_q;
        endcase
      end
    endcase
  end

  // FSM, PC, pending target and chip-enable registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= PC_S_OFF;
      pc_q      <= RESET_VEC;
      pend_pc_q <= '0;
      ce_q      <= ChipDisable;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      ce_q      <= ce_d;
    end
  end

  assign pc_o = pc_q;
  assign ce_o = ce_q;

`ifdef PC_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;

  // Flag follows each pc update: redirects re-evaluate it, increments clear it, holds keep it.
  always_comb begin
    misalign_d = misalign_q;
    if (state_q != PC_S_OFF && sel != SEL_HOLD && sel != SEL_CAP) begin
      misalign_d = misalign_nxt;
    end
  end

  // Misalign flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_o = misalign_q;
`else
  // Redirects are aligned on load, so nothing can be misaligned.
  logic unused_misalign;
  assign unused_misalign = misalign_nxt;
  assign misalign_o      = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset, increment, stall capture, flush, wait states, wrap, alignment.
// Latency: expectations assume one-cycle redirect and increment.
// Backpressure: exercised through stall_i[0] and inst_ready_i.
`timescale 1ns/1ps
import pc_gen_pkg::*;

module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        inst_ready_i;
  logic [31:0] pc_o;
  logic        ce_o;
  logic        misalign_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall_i                 (stall_i),
    .flush_i                 (flush_i),
    .new_pc_i                (new_pc_i),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .inst_ready_i            (inst_ready_i),
    .pc_o                    (pc_o),
    .ce_o                    (ce_o),
    .misalign_o              (misalign_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst                     = 1'b0;
    stall_i                 = NoStop;
    flush_i                 = 1'b0;
    new_pc_i                = '0;
    branch_flag_i           = 1'b0;
    branch_target_address_i = '0;
    inst_ready_i            = 1'b1;

    // Reset held
    tick(); tick();
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_ce", {31'd0, ce_o}, 32'd0);
    chk("rst_mis", {31'd0, misalign_o}, 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(PC_S_OFF));

    // Release: ce first, then sequential fetch
    rst = 1'b1;
    tick();
    chk("rel_ce", {31'd0, ce_o}, 32'd1);
    chk("rel_pc", pc_o, 32'h0);
    tick(); chk("inc_4", pc_o, 32'h4);
    tick(); chk("inc_8", pc_o, 32'h8);
    tick(); tick(); chk("inc_10", pc_o, 32'h10);

    // Branch under stall is captured, re-presented branch ignored
    stall_i = 6'b000001; branch_flag_i = 1'b1; branch_target_address_i = 32'h200;
    tick();
    chk("cap_hold1", pc_o, 32'h10);
    chk("cap_state", 32'(dut.state_q), 32'(PC_S_PEND));
    branch_target_address_i = 32'h300;
    tick(); chk("cap_hold2", pc_o, 32'h10);
    tick(); chk("cap_hold3", pc_o, 32'h10);
    chk("cap_pend", dut.pend_pc_q, 32'h200);
    stall_i = NoStop; branch_flag_i = 1'b0;
    tick();
    chk("cap_release", pc_o, 32'h200);
    chk("cap_run", 32'(dut.state_q), 32'(PC_S_RUN));

    // Flush while stalled and pending; flush also beats a concurrent branch
    stall_i = 6'b000001; branch_flag_i = 1'b1; branch_target_address_i = 32'h400;
    tick(); chk("fl_pend", 32'(dut.state_q), 32'(PC_S_PEND));
    flush_i = 1'b1; new_pc_i = 32'h20;
    tick();
    chk("fl_pc", pc_o, 32'h20);
    chk("fl_state", 32'(dut.state_q), 32'(PC_S_RUN));
    chk("fl_pend_clr", dut.pend_pc_q, 32'h0);
    flush_i = 1'b0; branch_flag_i = 1'b0;
    tick(); chk("fl_stall_hold", pc_o, 32'h20);
    stall_i = NoStop;
    tick(); chk("fl_then_inc", pc_o, 32'h24);

    // Wait states at 0x40
    flush_i = 1'b1; new_pc_i = 32'h40;
    tick(); chk("ws_start", pc_o, 32'h40);
    flush_i = 1'b0; inst_ready_i = 1'b0;
    tick(); chk("ws_hold1", pc_o, 32'h40);
    tick(); chk("ws_hold2", pc_o, 32'h40);
    inst_ready_i = 1'b1;
    tick(); chk("ws_resume", pc_o, 32'h44);

    // Wrap-around
    flush_i = 1'b1; new_pc_i = 32'hFFFF_FFFC;
    tick(); chk("wrap_pre", pc_o, 32'hFFFF_FFFC);
    flush_i = 1'b0;
    tick(); chk("wrap_post", pc_o, 32'h0);

    // Live branch with advance: one-cycle redirect
    branch_flag_i = 1'b1; branch_target_address_i = 32'h500;
    tick(); chk("br_live", pc_o, 32'h500);

    // Misaligned branch target
    branch_target_address_i = 32'h102;
    tick();
`ifdef PC_MISALIGN_CHK_EN
    chk("mis_pc", pc_o, 32'h102);
    chk("mis_flag", {31'd0, misalign_o}, 32'd1);
`else
    chk("mis_pc", pc_o, 32'h100);
    chk("mis_flag", {31'd0, misalign_o}, 32'd0);
`endif
    branch_flag_i = 1'b0;
    tick();
`ifdef PC_MISALIGN_CHK_EN
    chk("mis_inc_pc", pc_o, 32'h106);
`else
    chk("mis_inc_pc", pc_o, 32'h104);
`endif
    chk("mis_inc_flag", {31'd0, misalign_o}, 32'd0);
    chk("ce_steady", {31'd0, ce_o}, 32'd1);

    // Asynchronous reset while pending
    stall_i = 6'b000001; branch_flag_i = 1'b1; branch_target_address_i = 32'h600;
    tick(); chk("ar_pend", 32'(dut.state_q), 32'(PC_S_PEND));
    rst = 1'b0;
    #1;
    chk("ar_pc", pc_o, 32'h0);
    chk("ar_ce", {31'd0, ce_o}, 32'd0);
    chk("ar_state", 32'(dut.state_q), 32'(PC_S_OFF));
    chk("ar_pend_clr", dut.pend_pc_q, 32'h0);
    stall_i = NoStop; branch_flag_i = 1'b0;
    tick(); chk("ar_held_pc", pc_o, 32'h0);
    rst = 1'b1;
    tick();
    chk("ar_rel_ce", {31'd0, ce_o}, 32'd1);
    chk("ar_rel_pc", pc_o, 32'h0);
    tick(); chk("ar_rel_inc", pc_o, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-address generator for the IF stage; successor to the single-width PC register. Holds the program counter, drives the instruction-memory chip enable, and picks the next PC from exception flush, a captured branch, a live branch, or a sequential increment. Adds a configurable reset vector and width, instruction-memory wait states, and capture of branches that arrive while fetch is stalled.

## Interface
- ADDR_W, 32, PC and target width in bits.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset; must be INST_BYTES-aligned.
- INST_BYTES, 4, sequential increment in bytes; power of two, ≥1.
- STALL_W, 6, width of the stall vector from ctrl; only bit 0 is used.
- clk  in  1  sole clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_i  in  STALL_W  ctrl stall vector; bit 0 = 1 freezes the PC.
- flush_i  in  1  exception flush from ctrl; top-priority redirect.
- new_pc_i  in  ADDR_W  exception handler address, valid while flush_i = 1.
- branch_flag_i  in  1  branch taken, from ID.
- branch_target_address_i  in  ADDR_W  branch target, valid while branch_flag_i = 1.
- inst_ready_i  in  1  instruction memory accepted the fetch at pc_o this cycle.
- pc_o  out  ADDR_W  current fetch address.
- ce_o  out  1  instruction-memory enable.
- misalign_o  out  1  pc_o came from a misaligned redirect (see Configuration).

## Operation
- States: OFF, RUN, PEND.
- Reset, asynchronous, on rst = 0: state = OFF, pc_o = RESET_VEC, ce_o = 0, pend_pc = 0, misalign_o = 0.
- OFF: on the first clk edge with rst = 1, go to RUN and set ce_o = 1. pc_o is unchanged.
- advance = ce_o & ~stall_i[0] & inst_ready_i.
- Next-PC priority in RUN and PEND:
  - flush_i: pc_o ← new_pc_i, state ← RUN, pend_pc cleared. Applied regardless of stall_i or inst_ready_i.
  - PEND & advance: pc_o ← pend_pc, state ← RUN.
  - RUN & branch_flag_i & advance: pc_o ← branch_target_address_i.
  - RUN & branch_flag_i & ~advance: pend_pc ← branch_target_address_i, state ← PEND, pc_o held.
  - RUN & advance: pc_o ← pc_o + INST_BYTES.
  - Otherwise: hold.
- In PEND, further branch_flag_i is ignored; the stalled ID stage re-presents the same branch, and the first capture wins.
- Arithmetic: increment is modulo 2^ADDR_W, so with ADDR_W = 32, 32'hFFFF_FFFC + 4 → 32'h0000_0000. No carry out.
- Reset mid-operation (any state): immediately returns to the reset values above; pend_pc is discarded.
- flush_i and branch_flag_i in the same cycle: flush wins and the branch is dropped.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Redirect latency: 1 cycle. A flush, or a branch with advance = 1, in cycle N appears on pc_o in cycle N+1.
- A captured branch appears on pc_o one cycle after the first cycle in which advance = 1.
- ce_o rises exactly one cycle after reset release and stays high until the next reset.
- Wait state: while inst_ready_i = 0, pc_o is held stable for the memory.

## Configuration
- PC_MISALIGN_CHK_EN defined:
  - On any load from new_pc_i, branch_target_address_i or pend_pc, misalign_o is registered as OR of the source's low log2(INST_BYTES) bits.
  - The address is loaded unmodified.
  - misalign_o stays set until the next pc_o update, then clears or re-evaluates.
- PC_MISALIGN_CHK_EN undefined:
  - The low log2(INST_BYTES) bits of every redirect address are forced to 0 on load.
  - misalign_o is tied to 0.

## Structure
- Shared defines header holds:
  - state encodings PC_S_OFF, PC_S_RUN, PC_S_PEND;
  - the existing StallBus, NoStop, ChipEnable and ChipDisable constants;
  - default INST_BYTES.
- One combinational sub-module, pc_next_sel, implements the priority mux and the misalignment/mask logic.
- pc_gen keeps the FSM, the pc register, the pend_pc register and the ce register.

## Test plan
- Reset and release, inst_ready_i = 1, no stall:
  - during reset: pc_o = RESET_VEC, ce_o = 0;
  - edge 1 after release: ce_o = 1, pc_o = 0x0;
  - edges 2 and 3: pc_o = 0x4, 0x8.
- Branch while stall_i[0] = 1: pc_o = 0x10, target 0x200.
  - pc_o holds 0x10 for 3 stalled cycles; state = PEND.
  - A second branch to 0x300 is ignored.
  - The cycle after stall drops: pc_o = 0x200.
- Flush during stall and PEND, new_pc_i = 0x20: pc_o = 0x20 next cycle, pend_pc dropped, state = RUN.
- inst_ready_i = 0 for 2 cycles at pc_o = 0x40:
  - pc_o stays 0x40;
  - then 0x44 the cycle after ready returns.
- Wrap-around: pc_o = 0xFFFF_FFFC, advance → pc_o = 0x0000_0000.
- Misaligned branch target 0x102:
  - with PC_MISALIGN_CHK_EN: pc_o = 0x102, misalign_o = 1;
  - without it: pc_o = 0x100, misalign_o = 0.
  - Also assert rst low mid-PEND and check the immediate return to reset values.
